mem_access_unit: RTL

//  Parametrised MAR/MDR pair plus a memory-transaction controller for the LC3 datapath.
//  - MAR and MDR load from the datapath bus.
//  - Each access runs a request/ready handshake with a multi-cycle memory, so variable latency is tolerated.
//  - Returns an R (ready) flag to the control FSM.
//  - A wait-state timeout flags a memory that never answers.

---
 rtl/mem_if_pkg.sv | 13 +
 rtl/mem_wait_timer.sv | 37 +++
 rtl/mem_access_unit.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mem_if_pkg.sv
// Shared types and default widths for the LC3 memory access unit.
package mem_if_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_t;

  localparam int LC3_DATA_W = 16;
  localparam int LC3_ADDR_W = 16;

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-state counter for a memory access; expire pulses on the last allowed cycle.
module mem_wait_timer #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int CW = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CMAX = {CW{1'b1}};

  logic [CW-1:0] r_count;

  // Saturating so a disabled timeout can never wrap into a false expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != CMAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  generate
    if (TIMEOUT_CYC == 0) begin : g_no_timeout
      assign o_expire = 1'b0;
    end else begin : g_timeout
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);
      assign o_expire = i_enable && (r_count == LAST);
    end
  endgenerate

endmodule

// File: rtl/mem_access_unit.sv
// LC3 MAR/MDR pair with a request/ready memory transaction controller and timeout.
// Handshake: mem_req stays high from the edge that samples mio_en until the edge
// that samples mem_ready=1 (or the timeout); each sampled mem_ready ends one access.
module mem_access_unit
  import mem_if_pkg::*;
#(
  parameter int DATA_W      = LC3_DATA_W,
  parameter int ADDR_W      = LC3_ADDR_W,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] bus,
  input  logic              ld_mar,
  input  logic              ld_mdr,
  input  logic              mio_en,
  input  logic              r_w,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  input  logic              err_clr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mdr,
  output logic              r,
  output logic              err,
  output mem_state_t        dbg_state
);

  mem_state_t        r_state;
  logic [ADDR_W-1:0] r_mar;
  logic [DATA_W-1:0] r_mdr;
  logic              r_we_q;
  logic              r_mem_req;
  logic              r_mem_we;
  logic              r_rdy;
  logic              r_err;
  logic              w_in_access;
  logic              w_expire;

  assign w_in_access = (r_state == ACCESS);

  mem_wait_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (!w_in_access),
    .i_enable (w_in_access),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_mar     <= '0;
      r_mdr     <= '0;
      r_we_q    <= 1'b0;
      r_mem_req <= 1'b0;
      r_mem_we  <= 1'b0;
      r_rdy     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      // A timeout later in this block overrides a same-cycle clear.
      if (err_clr) r_err <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (ld_mar) r_mar <= bus[ADDR_W-1:0];
          if (ld_mdr && !mio_en) r_mdr <= bus;
          if (mio_en) begin
            r_state   <= ACCESS;
            r_we_q    <= r_w;
            r_mem_req <= 1'b1;
            r_mem_we  <= r_w;
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            r_state   <= DONE;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_rdy     <= 1'b1;
            if (!r_we_q) r_mdr <= mem_rdata;
          end else if (w_expire) begin
            r_state   <= DONE;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_rdy     <= 1'b1;
            r_err     <= 1'b1;
          end
        end
        DONE: begin
          if (ld_mar) r_mar <= bus[ADDR_W-1:0];
          if (ld_mdr && !mio_en) r_mdr <= bus;
          if (!mio_en) begin
            r_state <= IDLE;
            r_rdy   <= 1'b0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_mem_req <= 1'b0;
          r_mem_we  <= 1'b0;
          r_rdy     <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mar;
  assign mem_wdata = r_mdr;
  assign mdr       = r_mdr;
  assign r         = r_rdy;
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule
